// File: rtl/cpu_pkg.sv
// Shared CPU arithmetic package: datapath width, multiply/divide state
// encoding and the sign-fix helper shared by the multiplier and divider.
package cpu_pkg;

  localparam int CPU_WIDTH = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Two's-complement negate of a double-width result when neg is set.
  function automatic logic [2*CPU_WIDTH-1:0] neg_if(
    input logic [2*CPU_WIDTH-1:0] val,
    input logic                   neg
  );
    logic [2*CPU_WIDTH-1:0] one;
    one = {{(2*CPU_WIDTH-1){1'b0}}, 1'b1};
    return neg ? ((~val) + one) : val;
  endfunction

endpackage

// File: rtl/seq_mult.sv
// Radix-2 sequential shift-add multiplier (MULT/MULTU), falling-edge clocked
// to line up with the divider; fixed latency of WIDTH cycles per operation.
module seq_mult
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  input  logic             is_signed,
  input  logic             start,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  // state  | meaning
  // IDLE   | waiting for start; hi/lo hold the last result
  // RUN    | one shift-add iteration per cycle, WIDTH iterations total

  localparam int CW = $clog2(WIDTH);
  localparam int AW = 2*WIDTH + 1;

  mdu_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic              sign_q, sign_d;
  logic              signed_q, signed_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  mag_a, mag_b;
  logic [WIDTH:0]    upper_sum;

  // 0x80000000 negates to itself, which read as unsigned is exactly 2^31.
  assign mag_a = (is_signed && multiplicand[WIDTH-1]) ? ((~multiplicand) + WIDTH'(1))
                                                      : multiplicand;
  assign mag_b = (is_signed && multiplier[WIDTH-1])   ? ((~multiplier) + WIDTH'(1))
                                                      : multiplier;

  // Extra top accumulator bit keeps the carry of the upper-half add.
  assign upper_sum = acc_q[AW-1:WIDTH] + {1'b0, mcand_q};

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      sign_q   <= 1'b0;
      signed_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      sign_q   <= sign_d;
      signed_q <= signed_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    sign_d   = sign_q;
    signed_d = signed_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          acc_d    = {{(WIDTH+1){1'b0}}, mag_b};
          mcand_d  = mag_a;
          signed_d = is_signed;
          sign_d   = is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
        end
      end

      ST_RUN: begin
        if (acc_q[0]) begin
          acc_d = {upper_sum, acc_q[WIDTH-1:0]} >> 1;
        end else begin
          acc_d = acc_q >> 1;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;

  assign {hi, lo} = neg_if(acc_q[2*WIDTH-1:0], sign_q & signed_q);

endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; only the value 32 is required to work.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its falling edge, matching the divider's timing in the CPU.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port multiplicand  input  WIDTH  operand A.
REQ-005 SHALL have port multiplier  input  WIDTH  operand B.
REQ-006 SHALL have port is_signed  input  1  1 = two's-complement (MULT), 0 = unsigned (MULTU).
REQ-007 SHALL have port start  input  1  request a new multiply.
REQ-008 SHALL have port hi  output  WIDTH  upper half of the 2*WIDTH product.
REQ-009 SHALL have port lo  output  WIDTH  lower half of the 2*WIDTH product.
REQ-010 SHALL have port busy  output  1  multiply in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when hi/lo become valid.

Function
REQ-012 SHALL implement states IDLE and RUN; IDLE->RUN on start while busy=0; RUN->IDLE after exactly WIDTH iterations.
REQ-013 SHALL accept a request only when start=1 and busy=0 at a falling edge.
- Operands, is_signed and the result sign (A[msb] XOR B[msb], signed mode only) SHALL be latched at that edge.
- In signed mode the magnitudes SHALL be latched; in unsigned mode the operands SHALL be latched as-is.
REQ-014 SHALL ignore start while busy=1; latched operands SHALL be unaffected.
REQ-015 SHALL perform radix-2 shift-add: per RUN cycle, if the multiplier LSB=1 add the multiplicand magnitude into the upper half of a 2*WIDTH+1-bit accumulator, then shift right 1.
REQ-016 SHALL assert busy on the accept edge and deassert it on the WIDTH-th RUN edge, giving a latency of WIDTH (32) cycles from accept to busy=0.
REQ-017 SHALL pulse done for exactly one cycle, coincident with busy falling.
REQ-018 SHALL drive {hi,lo} as the magnitude product, two's-complement negated when the latched result sign=1.
- The sign fix SHALL be combinational from latched state only.
- Operand inputs SHALL NOT affect hi/lo after acceptance.
REQ-019 SHALL hold hi/lo stable from done until the next accepted start; during RUN, hi/lo values are undefined to the consumer.
REQ-020 SHALL handle signed -2^31 magnitude (0x80000000) as unsigned 2^31 without overflow.
REQ-021 SHALL accept start=1 in the same cycle done=1, since busy is already 0 in that cycle; the new operation begins without losing the previous result until that edge.
REQ-022 SHALL produce an exact result for zero operands and still take the full WIDTH cycles; there is no early termination.

Reset
REQ-023 SHALL, on reset=0 and independent of clock, force: state IDLE, busy=0, done=0, accumulator 0, latched sign 0, iteration count 0, hence hi=0 and lo=0.
REQ-024 SHALL abort any operation in progress on reset mid-RUN; after release, the block idles until a new start.

Structure
REQ-025 SHALL place the WIDTH default and the state encoding (IDLE, RUN) in the shared CPU package used by the divider.
REQ-026 SHALL size the iteration counter as clog2(WIDTH) bits and terminate on count = WIDTH-1.
REQ-027 SHALL be a single module with no sub-module; the negate-if-negative logic MAY be shared with the divider as a small helper function in the package.

Verification
REQ-028 unsigned 3 x 5, start one cycle -> busy high 32 cycles, done pulse, hi=0x00000000, lo=0x0000000F.
REQ-029 signed 0xFFFFFFF9 (-7) x 6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6.
REQ-030 signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000; unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 start held high and operands changed during RUN -> result reflects first operands only; a second op begins only at or after the done cycle.
REQ-032 reset asserted at iteration 10 -> busy=0, done=0, hi=lo=0 immediately; a following 2 x 2 unsigned -> lo=0x00000004 after 32 cycles.
